// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: load-use bubbles, multi-cycle MUL/DIV hold in EX,
// data-memory freeze, taken-branch flush, and a saturating stall-cycle counter.
module hazard_stall_unit #(
  parameter int unsigned MUL_STALL = 2,
  parameter int unsigned DIV_STALL = 32,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       ADDR_1_ID,
  input  logic [4:0]       ADDR_2_ID,
  input  logic             USES_RS1_ID,
  input  logic             USES_RS2_ID,
  input  logic [4:0]       REG_WRITE_ADDR_EX,
  input  logic             MEM_READ_EN_EX,
  input  logic             MD_OP_EX,
  input  logic             MD_IS_DIV_EX,
  input  logic             BRANCH_TAKEN_EX,
  input  logic             DMEM_BUSY,
  input  logic             STALL_CLR,
  output logic             PC_STALL,
  output logic             IF_ID_STALL,
  output logic             ID_EX_STALL,
  output logic             EX_MEM_STALL,
  output logic             MEM_WB_STALL,
  output logic             ID_EX_BUBBLE,
  output logic             EX_MEM_BUBBLE,
  output logic             IF_ID_FLUSH,
  output logic             MD_BUSY,
  output logic [CNT_W-1:0] STALL_CYCLES
);

  localparam int unsigned CW = 6;
  localparam logic [CW:0] MUL_N = (CW+1)'(MUL_STALL);
  localparam logic [CW:0] DIV_N = (CW+1)'(DIV_STALL);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  state_t        fsm;
  logic [CW-1:0] cnt;
  logic          md_release;

  logic [CW:0]   n_sel;
  logic [CW-1:0] cnt_load;
  logic          md_trigger;
  logic          md_stall;
  logic          load_use;

  assign n_sel      = MD_IS_DIV_EX ? DIV_N : MUL_N;
  assign cnt_load   = CW'(n_sel - (CW+1)'(2));
  assign md_trigger = (fsm == RUN) && MD_OP_EX && !md_release && (n_sel != '0);
  assign md_stall   = (fsm == MD_WAIT) || md_trigger;
  assign load_use   = MEM_READ_EN_EX && (REG_WRITE_ADDR_EX != 5'd0) &&
                      ((USES_RS1_ID && (ADDR_1_ID == REG_WRITE_ADDR_EX)) ||
                       (USES_RS2_ID && (ADDR_2_ID == REG_WRITE_ADDR_EX)));

  // Control outputs: freeze > MUL/DIV hold > branch flush > load-use bubble
  always_comb begin
    PC_STALL      = 1'b0;
    IF_ID_STALL   = 1'b0;
    ID_EX_STALL   = 1'b0;
    EX_MEM_STALL  = 1'b0;
    MEM_WB_STALL  = 1'b0;
    ID_EX_BUBBLE  = 1'b0;
    EX_MEM_BUBBLE = 1'b0;
    IF_ID_FLUSH   = 1'b0;
    MD_BUSY       = 1'b0;
    if (!RESET) begin
      if (DMEM_BUSY) begin
        PC_STALL     = 1'b1;
        IF_ID_STALL  = 1'b1;
        ID_EX_STALL  = 1'b1;
        EX_MEM_STALL = 1'b1;
        MEM_WB_STALL = 1'b1;
      end else if (md_stall) begin
        PC_STALL      = 1'b1;
        IF_ID_STALL   = 1'b1;
        ID_EX_STALL   = 1'b1;
        EX_MEM_BUBBLE = 1'b1;
        MD_BUSY       = 1'b1;
      end else if (BRANCH_TAKEN_EX) begin
        IF_ID_FLUSH  = 1'b1;
        ID_EX_BUBBLE = 1'b1;
      end else if (load_use) begin
        PC_STALL     = 1'b1;
        IF_ID_STALL  = 1'b1;
        ID_EX_BUBBLE = 1'b1;
      end
    end
  end

  // MUL/DIV wait sequencing and stall-cycle counter; a freeze holds the sequencer
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fsm          <= RUN;
      cnt          <= '0;
      md_release   <= 1'b0;
      STALL_CYCLES <= '0;
    end else begin
      if (STALL_CLR) begin
        STALL_CYCLES <= '0;
      end else if (PC_STALL && (STALL_CYCLES != '1)) begin
        STALL_CYCLES <= STALL_CYCLES + CNT_W'(1);
      end

      if (!DMEM_BUSY) begin
        md_release <= 1'b0;
        if (fsm == MD_WAIT) begin
          if (cnt == '0) begin
            fsm        <= RUN;
            md_release <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end else if (md_trigger) begin
          if (n_sel == (CW+1)'(1)) begin
            md_release <= 1'b1;
          end else begin
            fsm <= MD_WAIT;
            cnt <= cnt_load;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: main instance with default parameters, plus a
// narrow-counter instance (CNT_W=4, MUL_STALL=1) driven by the same stimulus.
module tb_hazard_stall_unit;

  logic       clk;
  logic       rst;
  logic [4:0] a1, a2, rd_ex;
  logic       u1, u2, mre, md, isdiv, br, busy, clr;

  logic pc_st, ifid_st, idex_st, exmem_st, memwb_st, idex_bub, exmem_bub, ifid_fl, md_busy;
  logic [31:0] stall_cnt;
  logic pc_st4, ifid_st4, idex_st4, exmem_st4, memwb_st4, idex_bub4, exmem_bub4, ifid_fl4, md_busy4;
  logic [3:0]  stall_cnt4;
  logic [8:0]  ctl;

  int total;
  int bad;

  // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB stall, ID_EX bubble, EX_MEM bubble, IF_ID flush, MD busy}
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110001000;
  localparam logic [8:0] MDS  = 9'b111000101;
  localparam logic [8:0] FRZ  = 9'b111110000;
  localparam logic [8:0] FL   = 9'b000001010;

  assign ctl = {pc_st, ifid_st, idex_st, exmem_st, memwb_st, idex_bub, exmem_bub, ifid_fl, md_busy};

  hazard_stall_unit dut (
    .CLK(clk), .RESET(rst), .ADDR_1_ID(a1), .ADDR_2_ID(a2), .USES_RS1_ID(u1), .USES_RS2_ID(u2),
    .REG_WRITE_ADDR_EX(rd_ex), .MEM_READ_EN_EX(mre), .MD_OP_EX(md), .MD_IS_DIV_EX(isdiv),
    .BRANCH_TAKEN_EX(br), .DMEM_BUSY(busy), .STALL_CLR(clr),
    .PC_STALL(pc_st), .IF_ID_STALL(ifid_st), .ID_EX_STALL(idex_st), .EX_MEM_STALL(exmem_st),
    .MEM_WB_STALL(memwb_st), .ID_EX_BUBBLE(idex_bub), .EX_MEM_BUBBLE(exmem_bub),
    .IF_ID_FLUSH(ifid_fl), .MD_BUSY(md_busy), .STALL_CYCLES(stall_cnt)
  );

  hazard_stall_unit #(.MUL_STALL(1), .DIV_STALL(32), .CNT_W(4)) dut4 (
    .CLK(clk), .RESET(rst), .ADDR_1_ID(a1), .ADDR_2_ID(a2), .USES_RS1_ID(u1), .USES_RS2_ID(u2),
    .REG_WRITE_ADDR_EX(rd_ex), .MEM_READ_EN_EX(mre), .MD_OP_EX(md), .MD_IS_DIV_EX(isdiv),
    .BRANCH_TAKEN_EX(br), .DMEM_BUSY(busy), .STALL_CLR(clr),
    .PC_STALL(pc_st4), .IF_ID_STALL(ifid_st4), .ID_EX_STALL(idex_st4), .EX_MEM_STALL(exmem_st4),
    .MEM_WB_STALL(memwb_st4), .ID_EX_BUBBLE(idex_bub4), .EX_MEM_BUBBLE(exmem_bub4),
    .IF_ID_FLUSH(ifid_fl4), .MD_BUSY(md_busy4), .STALL_CYCLES(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    a1 = 5'd0; a2 = 5'd0; rd_ex = 5'd0; u1 = 1'b0; u2 = 1'b0; mre = 1'b0;
    md = 1'b0; isdiv = 1'b0; br = 1'b0; busy = 1'b0; clr = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    md = 1'b1; busy = 1'b1; mre = 1'b1; rd_ex = 5'd3; a1 = 5'd3; u1 = 1'b1; br = 1'b1;
    cyc(); cyc();
    total++;
    if (ctl !== NONE) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, NONE); end
    total++;
    if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    idle();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_load_use();
    logic [31:0] c0;
    c0 = stall_cnt;
    mre = 1'b1; rd_ex = 5'd5; a1 = 5'd5; u1 = 1'b1;
    #1;
    total++;
    if (ctl !== LU) begin bad++; $display("FAIL lu_rs1 got=%b exp=%b", ctl, LU); end
    cyc();
    total++;
    if (stall_cnt !== c0 + 32'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, c0 + 32'd1); end
    mre = 1'b0;
    #1;
    total++;
    if (ctl !== NONE) begin bad++; $display("FAIL lu_after got=%b exp=%b", ctl, NONE); end
    cyc();
    mre = 1'b1; rd_ex = 5'd0; a1 = 5'd0; u1 = 1'b1;
    #1;
    total++;
    if (ctl !== NONE) begin bad++; $display("FAIL lu_x0 got=%b exp=%b", ctl, NONE); end
    cyc();
    rd_ex = 5'd7; a1 = 5'd1; a2 = 5'd7; u1 = 1'b1; u2 = 1'b1;
    #1;
    total++;
    if (ctl !== LU) begin bad++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, LU); end
    u2 = 1'b0;
    #1;
    total++;
    if (ctl !== NONE) begin bad++; $display("FAIL lu_rs2_unused got=%b exp=%b", ctl, NONE); end
    idle();
    cyc();
  endtask

  task automatic test_mul();
    logic [31:0] c0;
    c0 = stall_cnt;
    md = 1'b1; isdiv = 1'b0;
    #1;
    total++;
    if (ctl !== MDS) begin bad++; $display("FAIL mul_c1 got=%b exp=%b", ctl, MDS); end
    total++;
    if (md_busy4 !== 1'b1) begin bad++; $display("FAIL mul1_c1 got=%b exp=1", md_busy4); end
    cyc();
    total++;
    if (ctl !== MDS) begin bad++; $display("FAIL mul_c2 got=%b exp=%b", ctl, MDS); end
    total++;
    if (md_busy4 !== 1'b0) begin bad++; $display("FAIL mul1_c2 got=%b exp=0", md_busy4); end
    cyc();
    total++;
    if (ctl !== NONE) begin bad++; $display("FAIL mul_c3 got=%b exp=%b", ctl, NONE); end
    md = 1'b0;
    cyc();
    total++;
    if (stall_cnt !== c0 + 32'd2) begin bad++; $display("FAIL mul_cnt got=%0d exp=%0d", stall_cnt, c0 + 32'd2); end
    cyc();
  endtask

  task automatic count_md(input string name, input int exp_n);
    int n;
    n = 0;
    #1;
    while (md_busy && n < 60) begin
      n++;
      cyc();
      #1;
    end
    total++;
    if (n != exp_n) begin bad++; $display("FAIL %s got=%0d exp=%0d", name, n, exp_n); end
  endtask

  task automatic test_div();
    md = 1'b1; isdiv = 1'b1;
    count_md("div_len", 32);
    total++;
    if (ctl !== NONE) begin bad++; $display("FAIL div_release got=%b exp=%b", ctl, NONE); end
    md = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_freeze_div();
    logic [31:0] c0;
    int n;
    c0 = stall_cnt;
    n = 0;
    md = 1'b1; isdiv = 1'b1;
    for (int k = 0; k < 60; k++) begin
      busy = (k >= 10 && k < 13);
      #1;
      if (!pc_st) break;
      if (busy) begin
        total++;
        if (ctl[8:1] !== FRZ[8:1]) begin bad++; $display("FAIL freeze_ctl got=%b exp=%b", ctl[8:1], FRZ[8:1]); end
      end
      n++;
      cyc();
    end
    total++;
    if (n != 35) begin bad++; $display("FAIL freeze_len got=%0d exp=35", n); end
    total++;
    if (stall_cnt !== c0 + 32'd35) begin bad++; $display("FAIL freeze_cnt got=%0d exp=%0d", stall_cnt, c0 + 32'd35); end
    md = 1'b0; busy = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_priority();
    br = 1'b1; mre = 1'b1; rd_ex = 5'd9; a1 = 5'd9; u1 = 1'b1;
    #1;
    total++;
    if (ctl !== FL) begin bad++; $display("FAIL flush_lu got=%b exp=%b", ctl, FL); end
    busy = 1'b1;
    #1;
    total++;
    if (ctl[8:1] !== FRZ[8:1]) begin bad++; $display("FAIL freeze_over_flush got=%b exp=%b", ctl[8:1], FRZ[8:1]); end
    busy = 1'b0; br = 1'b0;
    cyc();
    br = 1'b1;
    mre = 1'b0;
    #1;
    total++;
    if (ctl !== FL) begin bad++; $display("FAIL flush_only got=%b exp=%b", ctl, FL); end
    br = 1'b0; mre = 1'b1; md = 1'b1; isdiv = 1'b0;
    #1;
    total++;
    if (ctl !== MDS) begin bad++; $display("FAIL md_blocks_lu got=%b exp=%b", ctl, MDS); end
    cyc();
    idle();
    cyc(); cyc(); cyc();
  endtask

  task automatic test_reset_mid();
    md = 1'b1; isdiv = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    rst = 1'b1;
    #1;
    total++;
    if (ctl !== NONE) begin bad++; $display("FAIL rst_mid_ctl got=%b exp=%b", ctl, NONE); end
    total++;
    if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", stall_cnt); end
    cyc();
    rst = 1'b0;
    count_md("rst_fresh_div", 32);
    total++;
    if (stall_cnt !== 32'd32) begin bad++; $display("FAIL rst_fresh_cnt got=%0d exp=32", stall_cnt); end
    md = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_saturate();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    total++;
    if (stall_cnt4 !== 4'd0) begin bad++; $display("FAIL clr4 got=%0d exp=0", stall_cnt4); end
    total++;
    if (stall_cnt !== 32'd0) begin bad++; $display("FAIL clr32 got=%0d exp=0", stall_cnt); end
    md = 1'b1; isdiv = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    total++;
    if (stall_cnt4 !== 4'd15) begin bad++; $display("FAIL sat4 got=%0d exp=15", stall_cnt4); end
    total++;
    if (stall_cnt !== 32'd20) begin bad++; $display("FAIL cnt20 got=%0d exp=20", stall_cnt); end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    total++;
    if (stall_cnt4 !== 4'd0) begin bad++; $display("FAIL clr_in_stall got=%0d exp=0", stall_cnt4); end
    cyc();
    total++;
    if (stall_cnt4 !== 4'd1) begin bad++; $display("FAIL count_after_clr got=%0d exp=1", stall_cnt4); end
    count_md("sat_div_tail", 10);
    md = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_load_use();
    test_mul();
    test_div();
    test_freeze_div();
    test_priority();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
